// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the 4:1 mux scan sequencer.
// Optional macro MUX_SCAN_CONTINUOUS_EN is consumed by mux41_scan_ctrl.
package mux_scan_pkg;
  localparam int NUM_CH = 4;
  localparam int SEL_W  = $clog2(NUM_CH);
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    DONE
  } scan_state_t;

  typedef logic [NUM_CH-1:0] scan_word_t;
  typedef logic [SEL_W-1:0]  scan_sel_t;

  function automatic logic is_last_ch(input scan_sel_t sel);
    return sel == SEL_W'(NUM_CH - 1);
  endfunction
endpackage

// File: rtl/mux41_scan_ctrl_settle_timer.sv
// Loadable down-counter with zero flag; counts the settle wait per channel.
// Holds at zero when decremented there, so a stray dec cannot wrap.
module settle_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);
  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_val;
    end else if (dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign zero = (r_count == '0);
endmodule

// File: rtl/mux41_scan_ctrl.sv
// Steps the 4:1 mux select, samples y per channel and offers the packed word on valid/ready.
// Define MUX_SCAN_CONTINUOUS_EN to restart a scan automatically after each accepted word.
module mux41_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [SEL_W-1:0]  s,
  input  logic              y,
  output logic              busy,
  output logic [NUM_CH-1:0] data_out,
  output logic              data_valid,
  input  logic              data_ready
);
  localparam logic [CNT_W-1:0] LP_RELOAD = CNT_W'(SETTLE_CYCLES - 1);

  scan_state_t         r_state;
  scan_state_t         w_state_next;
  scan_sel_t           r_sel;
  scan_sel_t           w_sel_next;
  logic [NUM_CH-2:0]   r_shadow;
  scan_word_t          r_data_out;
  logic                w_load;
  logic                w_dec;
  logic                w_zero;

  settle_timer #(
    .W (CNT_W)
  ) u_settle_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (w_load),
    .load_val (LP_RELOAD),
    .dec      (w_dec),
    .zero     (w_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_sel   <= '0;
    end else begin
      r_state <= w_state_next;
      r_sel   <= w_sel_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_sel_next   = r_sel;
    w_load       = 1'b0;
    w_dec        = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_next = SETTLE;
          w_sel_next   = '0;
          w_load       = 1'b1;
        end
      end
      SETTLE: begin
        if (w_zero) begin
          w_state_next = SAMPLE;
        end else begin
          w_dec = 1'b1;
        end
      end
      SAMPLE: begin
        if (is_last_ch(r_sel)) begin
          w_state_next = DONE;
        end else begin
          w_state_next = SETTLE;
          w_sel_next   = r_sel + 1'b1;
          w_load       = 1'b1;
        end
      end
      DONE: begin
        // start is deliberately ignored here; only the handshake moves us on
        if (data_ready) begin
`ifdef MUX_SCAN_CONTINUOUS_EN
          w_state_next = SETTLE;
          w_sel_next   = '0;
          w_load       = 1'b1;
`else
          w_state_next = IDLE;
`endif
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Channels 0..NUM_CH-2 park in the shadow; the last one goes straight into the word.
  for (genvar gi = 0; gi < NUM_CH - 1; gi++) begin : g_shadow
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_shadow[gi] <= 1'b0;
      end else if ((r_state == SAMPLE) && (r_sel == SEL_W'(gi))) begin
        r_shadow[gi] <= y;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data_out <= '0;
    end else if ((r_state == SAMPLE) && is_last_ch(r_sel)) begin
      r_data_out <= {y, r_shadow};
    end
  end

  assign s          = r_sel;
  assign busy       = (r_state == SETTLE) || (r_state == SAMPLE);
  assign data_valid = (r_state == DONE);
  assign data_out   = r_data_out;
endmodule

// File: doc/mux41_scan_ctrl.md
Name: mux41_scan_ctrl

Overview:
Sequencer that drives the select of the 4:1 channel mux and consumes its single-bit output. On each start it steps s through 0..3 and waits a programmable settle time per channel. It samples y per channel and packs the four samples into a 4-bit word. The word is offered downstream on a valid/ready handshake, so four parallel mux inputs are read back through one wire.

Parameters:
SETTLE_CYCLES, 1, cycles s is held stable before y is sampled; legal range 1..15.
NUM_CH, 4, channel count; fixed at 4, not overridable.
SEL_W, 2, select width, equal to $clog2(NUM_CH).

Ports:
clk  input  1  single system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  scan request; honoured only in IDLE.
s  output  SEL_W  mux select, wired to the mux s port.
y  input  1  mux output, sampled in SAMPLE state.
busy  output  1  high in SETTLE or SAMPLE.
data_out  output  NUM_CH  packed word; bit k is y observed with s=k.
data_valid  output  1  word available.
data_ready  input  1  downstream accepts word.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, s=0, busy=0, data_valid=0, data_out=0, settle counter=0, shadow register=0.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE, start=1 at edge E: next state SETTLE, s=0, counter=SETTLE_CYCLES-1.
- SETTLE: if counter==0, go to SAMPLE; else decrement the counter. SETTLE lasts exactly SETTLE_CYCLES cycles.
- SAMPLE (1 cycle): shadow[s] <= y on the exiting edge.
  - s<3: s increments and state returns to SETTLE with the counter reloaded.
  - s==3: data_out <= {y, shadow[2:0]}, state moves to DONE, s held at 3.
- DONE: data_valid=1 and data_out stable. When data_ready=1 at an edge, the state returns to IDLE and data_valid drops after that edge.
- Latency: data_valid is high after edge E+4*(SETTLE_CYCLES+1); with the default this is E+8.
- data_out changes only on entry to DONE. During a scan it keeps the previous word.
- start outside IDLE is ignored and not queued. start and data_ready asserted together in DONE: only the handshake is taken, and start is ignored.
- data_ready outside DONE has no effect.
- s wraps never: s stays in 0..3 and returns to 0 only via the IDLE+start transition or reset.
- Reset mid-scan: outputs return to reset values immediately, the partial shadow is discarded, and no data_valid pulse is produced.
- y is assumed settled by the SAMPLE cycle. The block samples only y and never resamples it.

Optional Feature:
MUX_SCAN_CONTINUOUS_EN.
- Defined: when the DONE handshake completes, the state goes directly to SETTLE with s=0 and the counter reloaded, without needing start. Back-to-back words are spaced 4*(SETTLE_CYCLES+1)+1 cycles apart when data_ready is held at 1. start still launches the first scan from IDLE.
- Undefined: after the handshake the state returns to IDLE and waits for start, as described above.

Decomposition:
- Package mux_scan_pkg holds:
  - NUM_CH and SEL_W localparams;
  - typedef enum logic [1:0] scan_state_t {IDLE, SETTLE, SAMPLE, DONE};
  - typedef logic [NUM_CH-1:0] scan_word_t.
- One sub-module is natural: settle_timer, a loadable down-counter with load, value and zero flag, reused for the settle wait.
- The FSM, shadow register and handshake stay in mux41_scan_ctrl.

Test Plan:
- Mux inputs i0..i3=1,0,1,1, SETTLE_CYCLES=1, start pulse at E, data_ready=1 → s sequence 0,0,1,1,2,2,3,3; data_valid high after E+8 with data_out=4'b1101; data_valid low one cycle later.
- Inputs 0,1,1,0 and data_ready held 0 for 5 cycles after valid → data_out=4'b0110 stable and data_valid high throughout; IDLE only after data_ready=1.
- Pulse start at cycle E+3 during a scan → ignored; exactly one word produced; the previous data_out is held until the DONE entry.
- Deassert rst_n at E+5 mid-scan → s=0, busy=0 and data_valid=0 immediately; a fresh scan after reset returns the correct full word.
- SETTLE_CYCLES=3, inputs all 1 → data_out=4'b1111 after E+16; s holds each value for 4 cycles.
- With MUX_SCAN_CONTINUOUS_EN defined and data_ready=1: a single start yields repeated words every 9 cycles (default settle); changing i2 mid-run is reflected in bit 2 of the next word.
